// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply sequencer: computes y = base^exp mod m by issuing
// left-to-right square/multiply requests to an external modular multiplier.
module mod_exp_ctrl #(
    parameter int NBITS = 2048,
    parameter int EBITS = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_p,
    input  logic [NBITS-1:0] base,
    input  logic [EBITS-1:0] exp,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] y,
    output logic             done_irq_p,
    output logic             err,
    output logic             busy,
    output logic             mm_enable_p,
    output logic [NBITS-1:0] mm_a,
    output logic [NBITS-1:0] mm_b,
    output logic [NBITS-1:0] mm_m,
    input  logic [NBITS-1:0] mm_y,
    input  logic             mm_done_irq_p
);

    localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;
    localparam logic [IW-1:0]    IDX_TOP  = IW'(EBITS - 1);
    localparam logic [IW-1:0]    IDX_ZERO = IW'(0);
    localparam logic [IW-1:0]    IDX_ONE  = IW'(1);
    localparam logic [NBITS-1:0] VAL_ZERO = NBITS'(0);
    localparam logic [NBITS-1:0] VAL_ONE  = NBITS'(1);
    localparam logic [NBITS-1:0] VAL_TWO  = NBITS'(2);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        SQR_REQ  = 3'd2,
        SQR_WAIT = 3'd3,
        MUL_REQ  = 3'd4,
        MUL_WAIT = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t            state_r;
    logic [NBITS-1:0]  base_r;
    logic [EBITS-1:0]  exp_r;
    logic [NBITS-1:0]  m_r;
    logic [NBITS-1:0]  res_r;
    logic [IW-1:0]     idx_r;

    // The modulus register doubles as the multiplier's modulus operand.
    assign mm_m = m_r;

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            base_r      <= VAL_ZERO;
            exp_r       <= '0;
            m_r         <= VAL_ZERO;
            res_r       <= VAL_ZERO;
            idx_r       <= IDX_ZERO;
            y           <= VAL_ZERO;
            done_irq_p  <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            mm_enable_p <= 1'b0;
            mm_a        <= VAL_ZERO;
            mm_b        <= VAL_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    done_irq_p <= 1'b0;
                    if (enable_p) begin
                        base_r <= base;
                        exp_r  <= exp;
                        m_r    <= m;
                        res_r  <= VAL_ONE;
                        idx_r  <= IDX_TOP;
                        busy   <= 1'b1;
                        if (m < VAL_TWO) begin
                            y          <= VAL_ZERO;
                            err        <= 1'b1;
                            done_irq_p <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            err     <= 1'b0;
                            state_r <= SCAN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SCAN: begin
                    if (exp_r[idx_r]) begin
                        // First multiply is 1*base, which also reduces base mod m.
                        mm_a        <= res_r;
                        mm_b        <= base_r;
                        mm_enable_p <= 1'b1;
                        state_r     <= MUL_REQ;
                    end else if (idx_r != IDX_ZERO) begin
                        idx_r <= idx_r - IDX_ONE;
                    end else begin
                        y          <= VAL_ONE;
                        done_irq_p <= 1'b1;
                        state_r    <= DONE;
                    end
                end
                SQR_REQ: begin
                    mm_enable_p <= 1'b0;
                    state_r     <= SQR_WAIT;
                end
                SQR_WAIT: begin
                    if (mm_done_irq_p) begin
                        res_r <= mm_y;
                        if (exp_r[idx_r]) begin
                            mm_a        <= mm_y;
                            mm_b        <= base_r;
                            mm_enable_p <= 1'b1;
                            state_r     <= MUL_REQ;
                        end else if (idx_r == IDX_ZERO) begin
                            y          <= mm_y;
                            done_irq_p <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            idx_r       <= idx_r - IDX_ONE;
                            mm_a        <= mm_y;
                            mm_b        <= mm_y;
                            mm_enable_p <= 1'b1;
                            state_r     <= SQR_REQ;
                        end
                    end else begin
                        state_r <= SQR_WAIT;
                    end
                end
                MUL_REQ: begin
                    mm_enable_p <= 1'b0;
                    state_r     <= MUL_WAIT;
                end
                MUL_WAIT: begin
                    if (mm_done_irq_p) begin
                        res_r <= mm_y;
                        if (idx_r == IDX_ZERO) begin
                            y          <= mm_y;
                            done_irq_p <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            idx_r       <= idx_r - IDX_ONE;
                            mm_a        <= mm_y;
                            mm_b        <= mm_y;
                            mm_enable_p <= 1'b1;
                            state_r     <= SQR_REQ;
                        end
                    end else begin
                        state_r <= MUL_WAIT;
                    end
                end
                DONE: begin
                    done_irq_p <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    done_irq_p  <= 1'b0;
                    busy        <= 1'b0;
                    mm_enable_p <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: multiplier responder plus a pow-mod reference model
// checked every cycle, with directed vectors pinning literal results.
module tb_mod_exp_ctrl;

    localparam int NB = 16;
    localparam int EB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_p;
    logic [NB-1:0] base;
    logic [EB-1:0] exp;
    logic [NB-1:0] m;
    logic [NB-1:0] y;
    logic          done_irq_p;
    logic          err;
    logic          busy;
    logic          mm_enable_p;
    logic [NB-1:0] mm_a;
    logic [NB-1:0] mm_b;
    logic [NB-1:0] mm_m;
    logic [NB-1:0] mm_y = 16'd0;
    logic          mm_done_irq_p = 1'b0;

    always #5 clk = ~clk;

    mod_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
        .clk(clk), .rst(rst), .enable_p(enable_p), .base(base), .exp(exp), .m(m),
        .y(y), .done_irq_p(done_irq_p), .err(err), .busy(busy),
        .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_y(mm_y), .mm_done_irq_p(mm_done_irq_p)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] required);
        n_total++;
        if (actual === required) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, actual, required, $time);
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } req_t;

    req_t        exp_q[$];
    req_t        log_q[$];
    logic [15:0] logy_q[$];
    req_t        rq;
    bit          act = 1'b0;
    bit          pending = 1'b0;
    bit          act_s;
    bit          pend_s;
    bit          exp_done;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          scan_c = 0;
    int          nreq = 0;
    int          sum_lat = 0;
    int          mm_cnt = 0;
    int          t_done;
    int          lat_mode = 0;
    logic [15:0] exp_y = 16'd0;
    logic [15:0] y_hold = 16'd0;
    logic [15:0] mdl_m = 16'd0;
    logic [15:0] h_a, h_b, h_m;
    logic        exp_err = 1'b0;
    logic        err_hold = 1'b0;

    function automatic logic [15:0] mulmod(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] md);
        logic [63:0] p;
        p = {48'd0, a} * {48'd0, b};
        return 16'(p % {48'd0, md});
    endfunction

    // Reference: y by repeated multiplication; request list from the exponent bits.
    task automatic model_accept();
        logic [15:0] r;
        req_t        q;
        int          k;
        mdl_m = m;
        exp_q.delete(); log_q.delete(); logy_q.delete();
        nreq = 0; sum_lat = 0;
        if (m < 16'd2) begin
            exp_y = 16'd0; exp_err = 1'b1; scan_c = 0;
        end else begin
            exp_err = 1'b0;
            r = 16'd1;
            for (int i = 0; i < int'(exp); i++) r = mulmod(r, base, m);
            exp_y = r;
            if (exp == 8'd0) begin
                scan_c = EB;
            end else begin
                k = 0;
                for (int i = 0; i < EB; i++) if (exp[i]) k = i;
                scan_c = EB - k;
                r = 16'd1;
                for (int i = k; i >= 0; i--) begin
                    if (i < k) begin
                        q.a = r; q.b = r; exp_q.push_back(q);
                        r = mulmod(r, r, m);
                    end
                    if (exp[i]) begin
                        q.a = r; q.b = base; exp_q.push_back(q);
                        r = mulmod(r, base, m);
                    end
                end
            end
        end
        act = 1'b1;
        acc_cyc = cyc;
    endtask

    // Multiplier responder and per-cycle comparison against the model.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            act = 1'b0; pending = 1'b0; mm_done_irq_p = 1'b0;
            y_hold = 16'd0; err_hold = 1'b0; exp_q.delete();
            chk("reset_outs", {12'd0, y, done_irq_p, err, busy, mm_enable_p}, 32'd0);
            chk("reset_mm_ab", {mm_a, mm_b}, 32'd0);
            chk("reset_mm_m", mm_m, 32'd0);
        end else begin
            if (mm_done_irq_p) mm_done_irq_p = 1'b0;
            pend_s = pending;
            act_s = act;
            if (pending) begin
                chk("mm_ab_stable", {mm_a, mm_b}, {h_a, h_b});
                chk("mm_m_stable", mm_m, h_m);
                mm_cnt--;
                if (mm_cnt == 0) begin
                    mm_y = mulmod(h_a, h_b, h_m);
                    mm_done_irq_p = 1'b1;
                    logy_q.push_back(mm_y);
                    pending = 1'b0;
                end
            end
            t_done = scan_c + nreq + sum_lat + 1;
            exp_done = act_s && (exp_q.size() == 0) && !pending && (cyc - acc_cyc == t_done);
            chk("done_irq_p", done_irq_p, exp_done);
            if (act_s && (done_irq_p || ((exp_q.size() == 0) && !pending && (cyc - acc_cyc > t_done)))) begin
                chk("y_at_done", y, exp_y);
                chk("err_at_done", err, exp_err);
                act = 1'b0; y_hold = exp_y; err_hold = exp_err;
            end
            chk("busy", busy, act_s);
            if (!act_s) begin
                chk("y_held", y, y_hold);
                chk("err_held", err, err_hold);
            end else if (!done_irq_p) begin
                chk("err_while_busy", err, 1'b0);
            end
            if (mm_enable_p) begin
                if (!act_s || pend_s || (exp_q.size() == 0)) begin
                    chk("mm_enable_p_unexpected", mm_enable_p, 1'b0);
                end else begin
                    rq = exp_q.pop_front();
                    chk("mm_a", mm_a, rq.a);
                    chk("mm_b", mm_b, rq.b);
                    chk("mm_m", mm_m, mdl_m);
                    rq.a = mm_a; rq.b = mm_b; log_q.push_back(rq);
                    h_a = mm_a; h_b = mm_b; h_m = mm_m;
                    pending = 1'b1;
                    mm_cnt = (lat_mode != 0) ? int'($urandom_range(20, 1)) : 3;
                    sum_lat += mm_cnt;
                    nreq++;
                end
            end
            if (enable_p && !act_s) model_accept();
        end
    end

    task automatic run_op(input logic [15:0] b, input logic [7:0] e, input logic [15:0] md,
                          input int dup_at, output int c);
        @(posedge clk); #1;
        base = b; exp = e; m = md; enable_p = 1'b1;
        @(posedge clk); #1;
        enable_p = 1'b0;
        c = 0;
        while (1) begin
            @(negedge clk);
            c++;
            if (done_irq_p) break;
            if (c > 3000) begin
                chk("done_timeout", done_irq_p, 1'b1);
                break;
            end
            @(posedge clk); #1;
            enable_p = (c == dup_at);
            if (c == dup_at) begin
                base = 16'd7; exp = 8'd3;
            end
        end
    endtask

    logic [31:0] s1_req[4] = '{{16'd1, 16'd1093}, {16'd1093, 16'd1093},
                               {16'd940, 16'd940}, {16'd1906, 16'd1093}};
    logic [15:0] s1_res[4] = '{16'd1093, 16'd940, 16'd1906, 16'd1816};
    int          c;
    bit          found;

    task automatic check_s1(input string tag);
        chk({tag, "_y"}, y, 16'd1816);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_nreq"}, log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk({tag, "_req"}, log_q[i], s1_req[i]);
        for (int i = 0; i < 4 && i < logy_q.size(); i++) chk({tag, "_res"}, logy_q[i], s1_res[i]);
    endtask

    initial begin
        rst = 1'b1; enable_p = 1'b0; base = 16'd0; exp = 8'd0; m = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("idle_y", y, 16'd0);
        chk("idle_flags", {done_irq_p, err, busy, mm_enable_p}, 4'd0);

        run_op(16'd1093, 8'd5, 16'd2013, 5, c);
        check_s1("s1");
        chk("s1_cycles", c, 23);

        run_op(16'd3000, 8'd1, 16'd2013, 0, c);
        chk("s2_y", y, 16'd987);
        chk("s2_cycles", c, 13);
        chk("s2_nreq", log_q.size(), 1);
        if (log_q.size() > 0) chk("s2_req", log_q[0], {16'd1, 16'd3000});

        run_op(16'd5, 8'd0, 16'd2013, 0, c);
        chk("exp0_y", y, 16'd1);
        chk("exp0_cycles", c, 9);
        chk("exp0_nreq", log_q.size(), 0);

        run_op(16'd5, 8'd5, 16'd1, 0, c);
        chk("m1_y", y, 16'd0);
        chk("m1_err", err, 1'b1);
        chk("m1_cycles", c, 1);
        chk("m1_nreq", log_q.size(), 0);

        run_op(16'd3000, 8'd1, 16'd2013, 0, c);
        chk("err_clear_y", y, 16'd987);
        chk("err_clear_err", err, 1'b0);

        // Reset while the first multiply is outstanding.
        @(posedge clk); #1;
        base = 16'd1093; exp = 8'd5; m = 16'd2013; enable_p = 1'b1;
        @(posedge clk); #1;
        enable_p = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 100 && !found; w++) begin
            @(negedge clk);
            found = mm_enable_p;
        end
        chk("rst_mid_mm_issued", found, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_y", y, 16'd0);
        chk("rst_mid_flags", {done_irq_p, err, busy, mm_enable_p}, 4'd0);
        chk("rst_mid_ops", {mm_a, mm_b}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(16'd1093, 8'd5, 16'd2013, 0, c);
        check_s1("after_rst");

        run_op(16'd9, 8'd3, 16'd0, 0, c);
        chk("m0_y", y, 16'd0);
        chk("m0_err", err, 1'b1);

        lat_mode = 1;
        run_op(16'd1093, 8'd5, 16'd2013, 0, c);
        check_s1("rand_s1");
        run_op(16'd65535, 8'd255, 16'd65521, 0, c);
        run_op(16'd2, 8'd128, 16'd1000, 0, c);
        chk("rand_pow2_y", y, 16'd456);
        run_op(16'd1234, 8'hA5, 16'd4097, 0, c);
        run_op(16'd5000, 8'd2, 16'd3, 0, c);
        chk("rand_small_m_y", y, 16'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Square-and-multiply sequencer that computes y = base^exp mod m by issuing a series of modular multiplications to an external `mod_mul_il` instance. It is the initiator side of the multiplier's `enable_p` / `done_irq_p` handshake. It sits between the crypto register file and the multiplier, and raises its own one-cycle completion pulse when the exponentiation is finished.

## Interface
- `NBITS`, 2048: width of base, modulus, result and multiplier operands.
- `EBITS`, 2048: exponent width. Bit index counter is `$clog2(EBITS)` bits.

- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `enable_p` in 1: one-cycle start pulse. Sampled only in IDLE.
- `base` in NBITS: base. Any value, including base ≥ m.
- `exp` in EBITS: exponent.
- `m` in NBITS: modulus.
- `y` out NBITS: result. Valid from the `done_irq_p` cycle; held until the next accepted start.
- `done_irq_p` out 1: one-cycle completion pulse.
- `err` out 1: set with `done_irq_p` when m < 2; cleared on the next accepted start.
- `busy` out 1: high in every state except IDLE.
- `mm_enable_p` out 1: one-cycle start pulse to the multiplier.
- `mm_a`, `mm_b`, `mm_m` out NBITS: multiplier operands. Registered and stable from the `mm_enable_p` cycle until `mm_done_irq_p`.
- `mm_y` in NBITS: multiplier result. Valid in the `mm_done_irq_p` cycle.
- `mm_done_irq_p` in 1: multiplier completion pulse.

## Operation
- **Reset values:** all outputs are 0; state is IDLE.
- **Internal registers:** `base_r`, `exp_r`, `m_r` (all latched on accept), `res`, `idx`, and the state register.
- **States:** IDLE, SCAN, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE.
- **IDLE:**
  - `enable_p`=1 → latch inputs, `res`←1, `idx`←EBITS-1, `err`←0.
  - If m < 2 → `y`←0, `err`←1, go to DONE.
  - Otherwise go to SCAN.
- **SCAN** (skips leading zero bits, one bit per cycle):
  - `exp_r[idx]`=1 → MUL_REQ. The first multiply is 1·base, which also reduces base mod m.
  - Bit is 0 and `idx`>0 → `idx`←`idx`-1, stay in SCAN.
  - Bit is 0 and `idx`=0 → DONE with `y`=1 (exp = 0).
- **SQR_REQ:** `mm_a`=`mm_b`=`res`, `mm_enable_p`=1 for this one cycle → SQR_WAIT.
- **SQR_WAIT:** on `mm_done_irq_p`, `res`←`mm_y`.
  - `exp_r[idx]`=1 → MUL_REQ.
  - Otherwise go to ADVANCE.
- **MUL_REQ:** `mm_a`=`res`, `mm_b`=`base_r`, `mm_enable_p`=1 for this one cycle → MUL_WAIT.
- **MUL_WAIT:** on `mm_done_irq_p`, `res`←`mm_y`, then go to ADVANCE.
- **ADVANCE** (this is a transition rule, not a state):
  - `idx`=0 → DONE with `y`←`res`.
  - Otherwise `idx`←`idx`-1 → SQR_REQ.
- **DONE:** `done_irq_p`=1 for one cycle → IDLE.
- `mm_m` = `m_r` throughout an operation.
- **Ignored events:**
  - `enable_p` while `busy` is ignored; no queuing.
  - `mm_done_irq_p` outside SQR_WAIT/MUL_WAIT is ignored.
- **Reset mid-operation:** immediate return to the reset state. `y` is cleared, no `done_irq_p` is produced, and `mm_enable_p` drops at once.

## Timing
- All outputs are registered.
- **Accept edge:** `enable_p` sampled high at edge E0 gives `busy`=1 in the cycle after E0.
- **Multiplier contract:** `mm_done_irq_p` arrives at least 1 cycle after `mm_enable_p`. Multiplier latency L is arbitrary.
- **Latency**, for exponent with top set bit at index k, popcount p, and multiplier latency L (each request costs 1 REQ cycle + L wait cycles):
  - Total = 1 + (EBITS-1-k) SCAN cycles + (k + p)·(1+L) + 1 DONE cycle.
  - exp = 0: `done_irq_p` in cycle EBITS+1 after E0.
  - m < 2: `done_irq_p` in cycle 1 after E0.
- Back-to-back operation: a new `enable_p` is accepted in the cycle after `done_irq_p`.

## Test plan
- NBITS=16, EBITS=8, fixed-latency multiplier model (L=3):
  - base=1093, exp=5, m=2013 → y=1816, err=0.
  - Exactly 4 `mm_enable_p` pulses in order MUL, SQR, SQR, MUL; intermediate `res` values are 1093, 940, 1906, 1816.
- base=3000, exp=1, m=2013 → single MUL, y=987.
- exp=0, m=2013 → no `mm_enable_p`, y=1, `done_irq_p` exactly 9 cycles after the accept edge.
- m=1 → y=0, err=1, `done_irq_p` 1 cycle after accept, no `mm_enable_p`.
- Second `enable_p` while busy is ignored and y is unchanged.
- Random-latency multiplier (1–20 cycles): operands stay stable across each wait, and results match a golden model.
- `rst` asserted during MUL_WAIT → all outputs 0 the same cycle. A subsequent run of the first scenario still yields 1816.
